rf_wb_arbiter: RTL

Shares the register file's single write port among NREQ writeback requesters (ALU, load unit, CSR/debug) using round-robin arbitration and a registered output stage. It also sequences a bulk clear of registers x1..x31 on command. The block sits between the writeback sources and the register file's rf_wen / rf_addr_w / rf_data_w inputs. It drops writes to x0 so the register file never holds a nonzero x0.

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_wb_arbiter_if.sv | 26 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the register-file writeback arbiter.
package rf_pkg;
  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  typedef enum logic {
    ST_RUN,
    ST_CLEAR
  } state_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bus plus the registered register-file write port.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_wen;
  logic [AW-1:0]      rf_addr_w;
  logic [DW-1:0]      rf_data_w;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_wen, rf_addr_w, rf_data_w
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_wen, rf_addr_w, rf_data_w
  );
endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant: round-robin from ptr_i, or lowest-index-wins when
// RF_WB_ARB_FIXED_PRIO_EN is defined (ptr_i is then ignored).
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o
);

`ifdef RF_WB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i] && (grant_o == '0)) grant_o[i] = 1'b1;
    end
  end
`else
  int          idx;
  logic [PW-1:0] idx_v;
  logic        found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    idx_v   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = PW'(idx);
      if (!found && req_i[idx_v]) begin
        grant_o[idx_v] = 1'b1;
        found          = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with x0 suppression and bulk clear of x1..x31.
// Build option: RF_WB_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_start,
  output logic clr_busy,
  rf_wb_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_addr_q, rf_addr_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;

  logic [NREQ-1:0] req_run, grant;
  logic            xfer;
  logic [PW-1:0]   gidx, ptr_arb;
  logic [AW-1:0]   gaddr;
  logic [DW-1:0]   gdata;

  // Requests are masked during the clear so no grant can escape.
  assign req_run = (state_q == ST_RUN) ? bus.req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i   (req_run),
    .ptr_i   (ptr_arb),
    .grant_o (grant)
  );

  assign xfer = |grant;

  always_comb begin
    gidx  = '0;
    gaddr = '0;
    gdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx  = PW'(i);
        gaddr = bus.req_addr[i*AW +: AW];
        gdata = bus.req_data[i*DW +: DW];
      end
    end
  end

`ifdef RF_WB_ARB_FIXED_PRIO_EN
  assign ptr_arb = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_arb = ptr_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rf_wen_d  = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    case (state_q)
      ST_RUN: begin
        if (xfer) begin
          rf_wen_d  = (gaddr != '0);
          rf_addr_d = gaddr;
          rf_data_d = gdata;
        end
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      ST_CLEAR: begin
        rf_wen_d  = 1'b1;
        rf_addr_d = cnt_q;
        rf_data_d = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(RF_NREG - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      rf_wen_q  <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_wen_q  <= rf_wen_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign clr_busy      = (state_q == ST_CLEAR);
  assign bus.req_ready = grant;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_addr_w = rf_addr_q;
  assign bus.rf_data_w = rf_data_q;

endmodule
